apb4_mem_slave: RTL

APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

---
 rtl/apb4_mem_slave_pkg.sv | 30 +++
 rtl/apb4_mem_slave_if.sv | 29 ++
 rtl/apb4_mem_slave_wait_cnt.sv | 35 +++
 rtl/apb4_mem_slave.sv | 134 +++++++++++++
 4 files changed

// File: rtl/apb4_mem_slave_pkg.sv
// apb4_pkg: definitions shared by the APB4 memory slave.
//   APB4_DATA_WIDTH   - width of the APB data buses and of each memory word
//   apb4_state_e      - transfer FSM states (IDLE, SETUP, ACCESS)
//   apb4_merge_bytes  - replaces only the byte lanes whose strobe bit is set
package apb4_pkg;

    localparam int APB4_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb4_state_e;

    function automatic logic [APB4_DATA_WIDTH-1:0] apb4_merge_bytes(
        input logic [APB4_DATA_WIDTH-1:0] old_word,
        input logic [APB4_DATA_WIDTH-1:0] new_word,
        input logic [3:0]                 strb
    );
        logic [APB4_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// apb4_mem_slave_if: APB4 bus signals between one master and one slave.
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb : master -> slave
//   pready, prdata, pslverr                            : slave -> master
// Clock and reset are not part of the bundle; they stay plain module ports.
interface apb4_mem_slave_if;
    import apb4_pkg::*;

    logic [31:0]                paddr;
    logic [2:0]                 pprot;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [APB4_DATA_WIDTH-1:0] pwdata;
    logic [3:0]                 pstrb;
    logic                       pready;
    logic [APB4_DATA_WIDTH-1:0] prdata;
    logic                       pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb4_mem_slave_wait_cnt.sv
// apb4_wait_cnt: wait-state down-counter for the APB4 memory slave.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val (takes priority over dec)
//   load_val - number of wait states for the new transfer
//   dec      - decrement by one while the count is non-zero
//   zero     - count is 0
//   expiring - count is 1, so the decrement at this edge reaches 0
module apb4_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero,
    output logic       expiring
);

    logic [3:0] count;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero     = (count == 4'd0);
    assign expiring = (count == 4'd1);

endmodule

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave: APB4 slave backed by DEPTH 32-bit words with byte strobes
// and a fixed number of wait states per transfer.
//   pclk   - clock, rising edge
//   preset - synchronous active-high reset; clears FSM, outputs and memory
//   bus    - apb4_mem_slave_if.slave (paddr, pprot, psel, penable, pwrite,
//            pwdata, pstrb in; pready, prdata, pslverr out, all registered)
// Parameters: DEPTH (words, power of two, >= 2), WAIT_CYCLES (0..15).
// Build option: define APB4_MEM_SLAVE_SLVERR_EN to flag invalid addresses on
// pslverr; otherwise pslverr is tied low.
module apb4_mem_slave
    import apb4_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              preset,
    apb4_mem_slave_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = APB4_DATA_WIDTH;

    apb4_state_e   state;
    logic [DW-1:0] mem [DEPTH];

    logic          cap_ok;
    logic          cap_write;
    logic [AW-1:0] cap_idx;
    logic [DW-1:0] cap_wdata;
    logic [3:0]    cap_strb;

    logic          live_ok;
    logic [AW-1:0] live_idx;
    logic          use_ok;
    logic          use_write;
    logic [AW-1:0] use_idx;
    logic [DW-1:0] use_wdata;
    logic [3:0]    use_strb;

    logic          start;
    logic          done;
    logic          cnt_zero;
    logic          cnt_expiring;

    apb4_wait_cnt u_wait_cnt (
        .clk      (pclk),
        .rst      (preset),
        .load     (start),
        .load_val (4'(WAIT_CYCLES)),
        .dec      ((state != IDLE) && bus.psel),
        .zero     (cnt_zero),
        .expiring (cnt_expiring)
    );

    // The setup phase is seen while still in IDLE, so with no wait states
    // the transfer completes at that same edge using the live bus values;
    // otherwise the values captured at setup are used.
    always_comb begin
        live_idx  = bus.paddr[AW+1:2];
        live_ok   = (bus.paddr[1:0] == 2'b00) && (bus.paddr[31:AW+2] == '0);
        start     = (state == IDLE) && bus.psel && !bus.penable;
        use_ok    = cap_ok;
        use_write = cap_write;
        use_idx   = cap_idx;
        use_wdata = cap_wdata;
        use_strb  = cap_strb;
        done      = 1'b0;
        if (state == IDLE) begin
            use_ok    = live_ok;
            use_write = bus.pwrite;
            use_idx   = live_idx;
            use_wdata = bus.pwdata;
            use_strb  = bus.pstrb;
            done      = start && (WAIT_CYCLES == 0);
        end else begin
            done      = bus.psel && (cnt_zero || cnt_expiring);
        end
    end

    // Transfer FSM, memory and registered outputs. Losing psel before
    // completion drops the transfer without touching memory.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            bus.pready  <= 1'b0;
            bus.prdata  <= '0;
            bus.pslverr <= 1'b0;
            cap_ok    <= 1'b0;
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_ok    <= live_ok;
                        cap_write <= bus.pwrite;
                        cap_idx   <= live_idx;
                        cap_wdata <= bus.pwdata;
                        cap_strb  <= bus.pstrb;
                        if (WAIT_CYCLES != 0) begin
                            state <= SETUP;
                        end
                    end
                end
                SETUP, ACCESS: begin
                    if (!bus.psel || done) begin
                        state <= IDLE;
                    end else begin
                        state <= ACCESS;
                    end
                end
                default: state <= IDLE;
            endcase

            bus.pready <= done;
            bus.prdata <= (done && !use_write && use_ok) ? mem[use_idx] : '0;
            if (done && use_write && use_ok) begin
                mem[use_idx] <= apb4_merge_bytes(mem[use_idx], use_wdata, use_strb);
            end
`ifdef APB4_MEM_SLAVE_SLVERR_EN
            bus.pslverr <= done && !use_ok;
`else
            bus.pslverr <= 1'b0;
`endif
        end
    end

endmodule
